// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : fir_pkg                                                   |
// | Purpose   : Shared sizing helpers and default coefficient set for     |
// |             the fir_smoother datapath.                                |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
package fir_pkg;

  // Ceiling log2, usable in constant (elaboration-time) expressions.
  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Accumulator width that holds the full sum of TAPS products without loss.
  function automatic int acc_width(input int width, input int coef_w, input int taps);
    return width + coef_w + clog2(taps);
  endfunction

  // Legacy [1,2,1] smoothing kernel, coef[0] in the LSBs.
  localparam logic [11:0] DEFAULT_COEF_INIT = {4'd1, 4'd2, 4'd1};

endpackage
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fir_delay_line                                            |
// | Purpose   : Enable-shift sample history; taps[0] is the most recent   |
// |             stored sample, taps[DEPTH-1] the oldest.                  |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module fir_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        clear,
  input  logic                        shift,
  input  logic [WIDTH-1:0]            d,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;

  // History advances only on accepted samples; clear wins over shift.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_taps <= '0;
    end else if (clear) begin
      r_taps <= '0;
    end else if (shift) begin
      r_taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  assign taps = r_taps;

endmodule
`default_nettype wire

// File: rtl/fir_smoother.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fir_smoother                                              |
// | Purpose   : Two-stage pipelined unsigned FIR smoother with loadable   |
// |             coefficients, optional rounding and output saturation.    |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module fir_smoother
  import fir_pkg::*;
#(
  parameter int                      WIDTH     = 8,
  parameter int                      TAPS      = 3,
  parameter int                      COEF_W    = 4,
  parameter int                      SHIFT     = 2,
  parameter int                      ROUND     = 0,
  parameter logic [TAPS*COEF_W-1:0]  COEF_INIT = DEFAULT_COEF_INIT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  a,
  input  logic              coef_load,
  input  logic [COEF_W-1:0] coef_in,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out
);

  localparam int ACC_W = acc_width(WIDTH, COEF_W, TAPS);
  // One guard bit so the rounding constant can never wrap a full-scale sum.
  localparam int SUM_W = ACC_W + 1;
  localparam int DEPTH = TAPS - 1;
  localparam logic [SUM_W-1:0] C_RND =
      (ROUND != 0 && SHIFT > 0) ? (SUM_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic [SUM_W-1:0] C_MAX = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic [TAPS-1:0][COEF_W-1:0] r_coef;
  logic [DEPTH-1:0][WIDTH-1:0] w_taps;
  logic [TAPS-1:0][WIDTH-1:0]  w_x;
  logic [TAPS-1:0][ACC_W-1:0]  r_prod;
  logic                        r_v1;
  logic                        w_accept;
  logic [SUM_W-1:0]            w_acc;
  logic [SUM_W-1:0]            w_shr;

  // A sample presented together with clear is discarded outright.
  assign w_accept = in_valid & ~clear;

  fir_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay_line (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clear (clear),
    .shift (w_accept),
    .d     (a),
    .taps  (w_taps)
  );

  // x[n] comes straight from the input; older samples from the delay line.
  assign w_x[0] = a;
  generate
    for (genvar k = 1; k < TAPS; k++) begin : g_x
      assign w_x[k] = w_taps[k-1];
    end
  endgenerate

  // Coefficient shift register: new value enters at the top, coef[0] drops out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_coef <= COEF_INIT;
    end else if (coef_load) begin
      r_coef <= {coef_in, r_coef[TAPS-1:1]};
    end
  end

  // Stage 1: register per-tap products using the coefficients of this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= ACC_W'(r_coef[k]) * ACC_W'(w_x[k]);
        end
      end
    end
  end

  // Sum of products plus the optional half-LSB rounding offset.
  always_comb begin
    w_acc = C_RND;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + SUM_W'(r_prod[k]);
    end
  end

  assign w_shr = w_acc >> SHIFT;

  // Stage 2: saturate into the output register; clear kills the stage-1 sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_v1 & ~clear;
      if (r_v1 && !clear) begin
        out <= (w_shr > C_MAX) ? {WIDTH{1'b1}} : w_shr[WIDTH-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_smoother.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_fir_smoother                                           |
// | Purpose   : Scoreboard bench for fir_smoother, truncating and         |
// |             rounding instances driven by the same stimulus.           |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fir_smoother;

  localparam int WIDTH  = 8;
  localparam int TAPS   = 3;
  localparam int COEF_W = 4;
  localparam int SHIFT  = 2;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              clear;
  logic              in_valid;
  logic [WIDTH-1:0]  a;
  logic              coef_load;
  logic [COEF_W-1:0] coef_in;
  logic              ov0, ov1;
  logic [WIDTH-1:0]  o0, o1;

  always #5 CLK = ~CLK;

  fir_smoother #(
    .WIDTH (WIDTH), .TAPS (TAPS), .COEF_W (COEF_W), .SHIFT (SHIFT), .ROUND (0)
  ) dut (
    .CLK (CLK), .RST_N (RST_N), .clear (clear), .in_valid (in_valid), .a (a),
    .coef_load (coef_load), .coef_in (coef_in), .out_valid (ov0), .out (o0)
  );

  fir_smoother #(
    .WIDTH (WIDTH), .TAPS (TAPS), .COEF_W (COEF_W), .SHIFT (SHIFT), .ROUND (1)
  ) dut_r (
    .CLK (CLK), .RST_N (RST_N), .clear (clear), .in_valid (in_valid), .a (a),
    .coef_load (coef_load), .coef_in (coef_in), .out_valid (ov1), .out (o1)
  );

  typedef struct {
    int edge_no;
    int e0;
    int e1;
  } scb_t;

  scb_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   coef_m[TAPS];
  int   hist_m[TAPS];   // hist_m[k] = x[n-k] for k >= 1
  int   last0 = 0;
  int   last1 = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Filter rule in plain integer arithmetic.
  function automatic int model_out(input int x0, input bit rnd);
    int acc;
    acc = coef_m[0] * x0;
    for (int k = 1; k < TAPS; k++) acc += coef_m[k] * hist_m[k];
    if (rnd) acc += (1 << (SHIFT - 1));
    acc = acc >> SHIFT;
    return (acc > MAXV) ? MAXV : acc;
  endfunction

  function automatic void model_reset();
    coef_m[0] = 1; coef_m[1] = 2; coef_m[2] = 1;
    for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
  endfunction

  // Present one cycle of inputs, update the model for the coming edge, then advance.
  task automatic drive(input bit iv, input int av, input bit cl, input bit ld, input int ci);
    scb_t e;
    in_valid  = iv;
    a         = av[WIDTH-1:0];
    clear     = cl;
    coef_load = ld;
    coef_in   = ci[COEF_W-1:0];
    if (cl) begin
      if (sb.size() > 0 && sb[$].edge_no == cyc + 1) void'(sb.pop_back());
      for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
    end else if (iv) begin
      e.edge_no = cyc + 2;
      e.e0      = model_out(av, 1'b0);
      e.e1      = model_out(av, 1'b1);
      sb.push_back(e);
      for (int k = TAPS - 1; k > 1; k--) hist_m[k] = hist_m[k-1];
      hist_m[1] = av;
    end
    if (ld) begin
      for (int k = 0; k < TAPS - 1; k++) coef_m[k] = coef_m[k+1];
      coef_m[TAPS-1] = ci;
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: every cycle, compare valid strobes, popped results and held outputs.
  always @(posedge CLK) begin
    scb_t e;
    bit   exp_v;
    #1;
    exp_v = (sb.size() > 0) && (sb[0].edge_no <= cyc);
    chk("out_valid", {31'd0, ov0}, {31'd0, exp_v});
    chk("out_valid_round", {31'd0, ov1}, {31'd0, exp_v});
    if (exp_v) begin
      e = sb.pop_front();
      chk("latency_edge", cyc, e.edge_no);
      chk("out", {24'd0, o0}, e.e0);
      chk("out_round", {24'd0, o1}, e.e1);
      last0 = e.e0;
      last1 = e.e1;
    end else begin
      chk("out_hold", {24'd0, o0}, last0);
      chk("out_hold_round", {24'd0, o1}, last1);
    end
  end

  initial begin
    RST_N = 1'b0; clear = 1'b0; in_valid = 1'b0; a = '0; coef_load = 1'b0; coef_in = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    chk("reset_out", {24'd0, o0}, 0);
    chk("reset_valid", {31'd0, ov0}, 0);
    RST_N = 1'b1;

    // Basic ramp: 4,8,12 -> 1,4,8
    drive(1, 4, 0, 0, 0); drive(1, 8, 0, 0, 0); drive(1, 12, 0, 0, 0);
    idle(3);
    chk("ramp_last", {24'd0, o0}, 8);

    // Idle gaps must not advance the history: 8,_,_,8 -> 2 then 6
    drive(0, 0, 1, 0, 0);
    drive(1, 8, 0, 0, 0); drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); drive(1, 8, 0, 0, 0);
    idle(3);
    chk("gap_result", {24'd0, o0}, 6);

    // All-15 kernel on full-scale input saturates
    drive(0, 0, 1, 1, 15); drive(0, 0, 0, 1, 15); drive(0, 0, 0, 1, 15);
    drive(1, 255, 0, 0, 0); drive(1, 255, 0, 0, 0); drive(1, 255, 0, 0, 0);
    idle(3);
    chk("saturate", {24'd0, o0}, 255);

    // Restore [1,2,1]; single a=2 -> 0 truncating, 1 rounding
    drive(0, 0, 0, 1, 1); drive(0, 0, 0, 1, 2); drive(0, 0, 1, 1, 1);
    drive(1, 2, 0, 0, 0);
    idle(3);
    chk("trunc_small", {24'd0, o0}, 0);
    chk("round_small", {24'd0, o1}, 1);

    // Load together with a sample: sample uses old kernel, next uses [2,1,0]
    drive(0, 0, 1, 0, 0);
    drive(1, 4, 0, 1, 0);
    drive(1, 4, 0, 0, 0);
    idle(3);
    chk("load_same_cycle", {24'd0, o0}, 3);
    drive(0, 0, 1, 1, 1); drive(0, 0, 0, 1, 2); drive(0, 0, 0, 1, 1);

    // Randomised traffic with occasional loads and clears
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 255),
            $urandom_range(0, 31) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 15));
    end

    // Running stream, one-cycle clear, then asynchronous reset mid-pipeline
    for (int i = 0; i < 4; i++) drive(1, $urandom_range(0, 255), 0, 0, 0);
    drive(1, $urandom_range(0, 255), 1, 0, 0);
    drive(1, $urandom_range(0, 255), 0, 0, 0);
    drive(1, $urandom_range(0, 255), 0, 0, 0);
    in_valid = 1'b0; clear = 1'b0; coef_load = 1'b0;
    RST_N = 1'b0;
    sb.delete();
    model_reset();
    last0 = 0;
    last1 = 0;
    #1;
    chk("async_reset_out", {24'd0, o0}, 0);
    chk("async_reset_valid", {31'd0, ov0}, 0);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    drive(1, 4, 0, 0, 0);
    idle(3);
    chk("post_reset", {24'd0, o0}, 1);

    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_smoother.md
# fir_smoother

Parametrised, pipelined unsigned FIR smoothing filter: output = saturate((Σ coef[k]·x[n−k] + rounding) >> SHIFT). Successor to the fixed 3-tap 8-bit [1,2,1]/4 smoother, adding configurable width and tap count, runtime-loadable coefficients, a valid handshake, rounding, saturation, flush and reset. Sits in the sample datapath between the input sampler and downstream decimation/compare logic.

## Interface
- WIDTH, 8, sample width (in and out), unsigned
- TAPS, 3, number of taps (≥2); delay line holds TAPS−1 samples
- COEF_W, 4, unsigned coefficient width
- SHIFT, 2, right-shift applied to the accumulator (0..ACC_W−1)
- ROUND, 0, 1 = add 2^(SHIFT−1) before shift (ignored when SHIFT=0)
- COEF_INIT, {4'd1,4'd2,4'd1}, TAPS·COEF_W packed reset coefficients; coef[0] in LSBs
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of delay line and pipeline
- in_valid  in  1  sample strobe
- a  in  WIDTH  input sample
- coef_load  in  1  shift one coefficient in
- coef_in  in  COEF_W  coefficient value
- out_valid  out  1  result strobe
- out  out  WIDTH  filtered result

## Operation
- x[n]=a when in_valid; x[n−k] (k≥1) from delay line, which shifts only on in_valid (idle cycles do not advance it).
- ACC_W = WIDTH+COEF_W+clog2(TAPS). All arithmetic unsigned, at ACC_W; no intermediate truncation.
- Stage 1 (on in_valid): register TAPS products p[k]=coef[k]·x[n−k]; v1<=1. Otherwise v1<=0.
- Stage 2: acc=Σp[k] (+2^(SHIFT−1) if ROUND and SHIFT>0); r=acc>>SHIFT; out<=min(r, 2^WIDTH−1); out_valid<=v1.
- out holds its last value when out_valid=0.
- coef_load: coef[i]<=coef[i+1] for i<TAPS−1, coef[TAPS−1]<=coef_in. After TAPS loads, the first value loaded sits in coef[0].
- coef_load and in_valid in same cycle: the sample uses the pre-update coefficients; the update applies from the next sample.
- clear: delay line<=0, v1<=0, out_valid<=0; coefficients and out retained. clear dominates in_valid in the same cycle (sample discarded). coef_load still honoured during clear.
- RST_N low (any time, including mid-pipeline): delay line<=0, products<=0, coef<=COEF_INIT, v1<=0, out<=0, out_valid<=0, immediately and without waiting for a clock edge.

## Timing
- Latency: in_valid at edge N → out_valid/out at edge N+2; fully pipelined, one sample per cycle throughput.
- Back-to-back in_valid gives back-to-back out_valid; gaps propagate 1:1.
- Reset values: out=0, out_valid=0. First valid after reset sees x[n−k]=0 for k≥1.
- Samples in flight when clear asserts: any sample already in stage 1 is dropped (no out_valid).
- No backpressure; the consumer must accept every out_valid.

## Structure
- Package fir_pkg: clog2 constant function, ACC_W derivation helper, default COEF_INIT localparam.
- Sub-module fir_delay_line (WIDTH, DEPTH=TAPS−1; ports CLK, RST_N, clear, shift, d, taps[]) – enable-shift register with async reset.
- Top holds the coefficient shift register, product stage and sum/round/saturate stage.

## Test plan
- Defaults, in_valid every cycle, a=4,8,12 → out 1,4,8 on out_valid at edges 2,3,4 after first input.
- in_valid pattern 1,0,0,1 with a=8 then 8 → second result (8+16)>>2=6; no out_valid during gap; delay line not advanced during idle cycles.
- Load coef 15,15,15 (three coef_load pulses), feed a=255 ×3 → third result 11475>>2=2868 saturates to out=255.
- ROUND=1, defaults, single a=2 after reset → out=1 (ROUND=0 gives 0).
- coef_load with coef_in=0 in the same cycle as in_valid a=4 → that sample yields 1; next sample reflects the new coef[TAPS−1]=0.
- Stream running, assert clear one cycle, then RST_N low mid-pipeline → in-flight results suppressed; after reset out=0, out_valid=0, coef=[1,2,1], next a=4 → out 1.
